// File: rtl/seq_div_if.sv
// Start/done handshake and result bus for the seq_div sequential divider.
// master drives operands and start; slave (the divider) returns the results.
interface seq_div_if #(
    parameter int a_width = 22,
    parameter int b_width = 22
);
    logic               start;
    logic [a_width-1:0] a;
    logic [b_width-1:0] b;
    logic               busy;
    logic               done;
    logic [a_width-1:0] quotient;
    logic [a_width-1:0] remainder;
    logic               divide_by_0;

    modport master (
        output start, a, b,
        input  busy, done, quotient, remainder, divide_by_0
    );

    modport slave (
        input  start, a, b,
        output busy, done, quotient, remainder, divide_by_0
    );
endinterface

// File: rtl/seq_div.sv
// Restoring radix-2 sequential divider, one quotient bit per cycle, signed or unsigned.
// Optional macro SEQ_DIV_OVF_SAT_EN: saturate quotient of most-negative / -1 to max positive.
module seq_div #(
    parameter int a_width  = 22,
    parameter int b_width  = 22,
    parameter int tc_mode  = 1,
    parameter int rem_mode = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_div_if.slave   bus
);
    localparam int cnt_w = $clog2(a_width);
    localparam logic [a_width-1:0] min_val = {1'b1, {(a_width-1){1'b0}}};
    localparam logic [a_width-1:0] max_val = ~min_val;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic [cnt_w-1:0]   cnt;
    logic [a_width-1:0] dq;
    logic [a_width-1:0] a_reg;
    logic [a_width-1:0] b_ext;
    logic [b_width-1:0] b_mag;
    logic [b_width:0]   rem_r;
    logic               a_neg;
    logic               b_neg;
    logic               div0_r;
`ifdef SEQ_DIV_OVF_SAT_EN
    logic               ovf_r;
`endif

    logic               busy_r;
    logic               done_r;
    logic [a_width-1:0] quot_r;
    logic [a_width-1:0] rem_out_r;
    logic               div0_out_r;

    logic               in_a_neg;
    logic               in_b_neg;
    logic [a_width-1:0] in_a_mag;
    logic [b_width-1:0] in_b_mag;
    logic [a_width-1:0] in_b_ext;

    logic [b_width:0]   shifted;
    logic [b_width:0]   diff;
    logic               trial_neg;

    logic [a_width-1:0] r_mag;
    logic [a_width-1:0] fix_q;
    logic [a_width-1:0] fix_r;

    assign in_a_neg = (tc_mode != 0) && bus.a[a_width-1];
    assign in_b_neg = (tc_mode != 0) && bus.b[b_width-1];
    assign in_a_mag = in_a_neg ? -bus.a : bus.a;
    assign in_b_mag = in_b_neg ? -bus.b : bus.b;
    assign in_b_ext = (tc_mode != 0) ? a_width'($signed(bus.b)) : a_width'(bus.b);

    // Partial remainder is one bit wider than the divisor so |b| never overflows the trial.
    assign shifted   = {rem_r[b_width-1:0], dq[a_width-1]};
    assign diff      = shifted - {1'b0, b_mag};
    assign trial_neg = shifted < {1'b0, b_mag};

    assign r_mag = a_width'(rem_r);

    always_comb begin
        fix_q = dq;
        fix_r = r_mag;
        if (div0_r) begin
            fix_r = a_reg;
            if (tc_mode != 0)
                fix_q = a_neg ? min_val : max_val;
            else
                fix_q = '1;
        end else if (tc_mode != 0) begin
            fix_q = (a_neg ^ b_neg) ? -dq : dq;
            fix_r = a_neg ? -r_mag : r_mag;
            // Modulus: a nonzero remainder with the dividend's sign is moved into the divisor's sign.
            if ((rem_mode == 0) && (r_mag != '0) && (a_neg != b_neg))
                fix_r = fix_r + b_ext;
`ifdef SEQ_DIV_OVF_SAT_EN
            if (ovf_r)
                fix_q = max_val;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            dq         <= '0;
            a_reg      <= '0;
            b_ext      <= '0;
            b_mag      <= '0;
            rem_r      <= '0;
            a_neg      <= 1'b0;
            b_neg      <= 1'b0;
            div0_r     <= 1'b0;
`ifdef SEQ_DIV_OVF_SAT_EN
            ovf_r      <= 1'b0;
`endif
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            quot_r     <= '0;
            rem_out_r  <= '0;
            div0_out_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg  <= bus.a;
                        b_ext  <= in_b_ext;
                        a_neg  <= in_a_neg;
                        b_neg  <= in_b_neg;
                        dq     <= in_a_mag;
                        b_mag  <= in_b_mag;
                        rem_r  <= '0;
                        cnt    <= '0;
                        div0_r <= (bus.b == '0);
`ifdef SEQ_DIV_OVF_SAT_EN
                        ovf_r  <= in_a_neg && (bus.a == min_val) && (bus.b == '1);
`endif
                        busy_r <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rem_r <= trial_neg ? shifted : diff;
                    dq    <= {dq[a_width-2:0], ~trial_neg};
                    cnt   <= cnt + 1'b1;
                    if (cnt == cnt_w'(a_width - 1))
                        state <= FIX;
                end
                FIX: begin
                    quot_r     <= fix_q;
                    rem_out_r  <= fix_r;
                    div0_out_r <= div0_r;
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_out_r;
    assign bus.divide_by_0 = div0_out_r;
endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: three builds (signed/rem, signed/modulus, unsigned)
// share one stimulus stream and are compared against an arithmetic reference model.
module tb_seq_div;
    localparam int AW = 22;
    localparam int BW = 22;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_s;
    logic [AW-1:0] a_s;
    logic [BW-1:0] b_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_div_if #(.a_width(AW), .b_width(BW)) if_def ();
    seq_div_if #(.a_width(AW), .b_width(BW)) if_mod ();
    seq_div_if #(.a_width(AW), .b_width(BW)) if_uns ();

    assign if_def.start = start_s;
    assign if_def.a     = a_s;
    assign if_def.b     = b_s;
    assign if_mod.start = start_s;
    assign if_mod.a     = a_s;
    assign if_mod.b     = b_s;
    assign if_uns.start = start_s;
    assign if_uns.a     = a_s;
    assign if_uns.b     = b_s;

    seq_div #(.a_width(AW), .b_width(BW), .tc_mode(1), .rem_mode(1)) dut_def (
        .clk(clk), .rst_n(rst_n), .bus(if_def.slave));
    seq_div #(.a_width(AW), .b_width(BW), .tc_mode(1), .rem_mode(0)) dut_mod (
        .clk(clk), .rst_n(rst_n), .bus(if_mod.slave));
    seq_div #(.a_width(AW), .b_width(BW), .tc_mode(0), .rem_mode(1)) dut_uns (
        .clk(clk), .rst_n(rst_n), .bus(if_uns.slave));

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division on sign- or zero-extended operands.
    task automatic model(input logic [AW-1:0] ma, input logic [BW-1:0] mb, input bit tc, input bit rm,
                         output logic [AW-1:0] q, output logic [AW-1:0] r, output logic z);
        longint av, bv, qv, rv;
        if (tc) begin
            av = longint'($signed(ma));
            bv = longint'($signed(mb));
        end else begin
            av = longint'({42'b0, ma});
            bv = longint'({42'b0, mb});
        end
        z = (bv == 0);
        if (z) begin
            r = ma;
            if (tc) q = (av < 0) ? 22'h200000 : 22'h1FFFFF;
            else    q = 22'h3FFFFF;
        end else if (tc && av == -longint'(2097152) && bv == -1) begin
            r = '0;
`ifdef SEQ_DIV_OVF_SAT_EN
            q = 22'h1FFFFF;
`else
            q = 22'h200000;
`endif
        end else begin
            qv = av / bv;
            rv = av % bv;
            if (tc && !rm && rv != 0 && ((rv < 0) != (bv < 0)))
                rv = rv + bv;
            q = qv[AW-1:0];
            r = rv[AW-1:0];
        end
    endtask

    task automatic check_results(input logic [AW-1:0] ta, input logic [BW-1:0] tb_);
        logic [AW-1:0] q, r;
        logic          z;
        model(ta, tb_, 1'b1, 1'b1, q, r, z);
        check_output("def.quotient", if_def.quotient, q);
        check_output("def.remainder", if_def.remainder, r);
        check_output("def.divide_by_0", if_def.divide_by_0, z);
        model(ta, tb_, 1'b1, 1'b0, q, r, z);
        check_output("mod.quotient", if_mod.quotient, q);
        check_output("mod.remainder", if_mod.remainder, r);
        check_output("mod.done", if_mod.done, 1);
        model(ta, tb_, 1'b0, 1'b1, q, r, z);
        check_output("uns.quotient", if_uns.quotient, q);
        check_output("uns.remainder", if_uns.remainder, r);
        check_output("uns.divide_by_0", if_uns.divide_by_0, z);
        check_output("uns.done", if_uns.done, 1);
    endtask

    // Launch one operation, optionally pulse start mid-flight, wait for done and check.
    task automatic apply_stimulus(input logic [AW-1:0] ta, input logic [BW-1:0] tb_, input bit interfere);
        int n;
        @(negedge clk);
        start_s = 1'b1;
        a_s     = ta;
        b_s     = tb_;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        a_s     = AW'($urandom);
        b_s     = BW'($urandom);
        n = 1;
        while (!if_def.done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (interfere && n == 5) begin
                start_s = 1'b1;
                a_s     = 22'h000123;
                b_s     = 22'h000005;
            end else begin
                start_s = 1'b0;
            end
        end
        check_output("latency", n, AW + 2);
        check_output("busy_at_done", if_def.busy, 0);
        check_results(ta, tb_);
    endtask

    initial begin
        int done_seen;
        logic [AW-1:0] ra;
        logic [BW-1:0] rb;
        rst_n   = 1'b0;
        start_s = 1'b0;
        a_s     = '0;
        b_s     = '0;
        #12;
        check_output("reset.busy", if_def.busy, 0);
        check_output("reset.done", if_def.done, 0);
        check_output("reset.quotient", if_def.quotient, 0);
        check_output("reset.remainder", if_def.remainder, 0);
        check_output("reset.divide_by_0", if_def.divide_by_0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(22'd7, 22'd3, 1'b0);
        check_output("7/3.q", if_def.quotient, 22'd2);
        check_output("7/3.r", if_def.remainder, 22'd1);
        apply_stimulus(22'h3FFA08, 22'd19, 1'b0);
        check_output("-1528/19.q", if_def.quotient, 22'h3FFFB0);
        check_output("-1528/19.r", if_def.remainder, 22'h3FFFF8);
        check_output("-1528/19.mod.r", if_mod.remainder, 22'd11);
        apply_stimulus(22'h3FFFFF, 22'd0, 1'b0);
        check_output("uns.div0.q", if_uns.quotient, 22'h3FFFFF);
        check_output("uns.div0.flag", if_uns.divide_by_0, 1);
        apply_stimulus(22'h200000, 22'h3FFFFF, 1'b0);
        check_output("ovf.r", if_def.remainder, 0);
        apply_stimulus(22'h000123, 22'h3FFFF0, 1'b1);

        // Abort an operation with reset: outputs clear and no done ever follows.
        @(negedge clk);
        start_s = 1'b1;
        a_s     = 22'd100;
        b_s     = 22'd7;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("abort.busy", if_def.busy, 0);
        check_output("abort.quotient", if_def.quotient, 0);
        check_output("abort.remainder", if_def.remainder, 0);
        done_seen = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (if_def.done) done_seen++;
        end
        check_output("abort.no_done", done_seen, 0);
        apply_stimulus(22'd100, 22'd7, 1'b1);
        check_output("100/7.q", if_def.quotient, 22'd14);
        check_output("100/7.r", if_def.remainder, 22'd2);

        for (int i = 0; i < 40; i++) begin
            ra = AW'($urandom);
            rb = BW'($urandom);
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = BW'($urandom_range(1, 15));
                2: rb = -BW'($urandom_range(1, 15));
                3: begin ra = 22'h200000; rb = '1; end
                default: ;
            endcase
            apply_stimulus(ra, rb, i[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Multi-cycle integer divider (restoring, radix-2, one quotient bit per cycle) with start/done handshake.
- Computes quotient and remainder of an a_width-bit dividend by a b_width-bit divisor, signed or unsigned.
- Flags divide-by-zero.
- Used by the k-means datapath for centroid averaging; replaces a combinational divider to shorten the critical path.

Parameters:
- a_width, 22, dividend/quotient/remainder width; must be ≥ 2.
- b_width, 22, divisor width; must satisfy 2 ≤ b_width ≤ a_width.
- tc_mode, 1: 1 = two's-complement signed operands/results; 0 = unsigned.
- rem_mode, 1: 1 = remainder takes the sign of the dividend (C "%"); 0 = modulus, sign of the divisor.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while busy=0.
- a  in  a_width  dividend, sampled with start.
- b  in  b_width  divisor, sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse: results valid.
- quotient  out  a_width  registered quotient.
- remainder  out  a_width  registered remainder (sign-extended per tc_mode).
- divide_by_0  out  1  registered; high when the captured b == 0.

Behaviour:
- Reset (async assert, sync release): busy=0, done=0, quotient=0, remainder=0, divide_by_0=0; FSM to IDLE. Reset mid-operation aborts with no done.
- FSM states: IDLE, CALC, FIX.
- IDLE: on an edge with start=1, capture a and b, record the operand signs (tc_mode=1), load the magnitudes, clear the iteration counter, go to CALC, busy=1.
- CALC: exactly a_width cycles. Each cycle: shift partial remainder left by one, bringing in the next dividend MSB; subtract |b|; if the result is non-negative, keep it and shift in quotient bit 1, else shift in 0.
- FIX: apply signs, register outputs, pulse done=1 for one cycle, busy=0, return to IDLE.
- Latency: done is high in the cycle after the (a_width+2)th rising edge counted from the edge that sampled start. This is 24 edges at default parameters.
- Latency is fixed and independent of operand values, including divide-by-zero.
- start while busy=1 is ignored.
- start may be asserted in the same cycle done is high; the new operation begins.
- Outputs hold their last result until the next FIX.
- Signed (tc_mode=1):
  - quotient truncates toward zero; negated if the operand signs differ.
  - rem_mode=1: remainder has the sign of a, and a = q*b + r.
  - rem_mode=0: if the remainder is nonzero and its sign differs from b, add b.
- Unsigned (tc_mode=0): plain magnitudes; rem_mode has no effect.
- Divide by zero (b==0):
  - divide_by_0=1 and remainder=a.
  - quotient = all ones if tc_mode=0.
  - If tc_mode=1: quotient = max positive when a ≥ 0, most negative when a < 0.
- divide_by_0 is 0 for every non-zero divisor result.
- Overflow case: tc_mode=1, a = most negative, b = −1. Remainder = 0; quotient per the optional feature.
- Internal partial remainder is b_width+1 bits wide, so |b| never overflows.

Optional Feature:
- Macro: SEQ_DIV_OVF_SAT_EN.
- Defined: in the signed overflow case (most-negative / −1), quotient saturates to max positive (22'h1FFFFF at defaults).
- Not defined: quotient wraps to the two's-complement truncation, i.e. most negative (22'h200000).
- No port difference between the two builds.

Test Plan:
- Defaults, a=7, b=3, start pulse → done after 24 edges; quotient=2, remainder=1, divide_by_0=0.
- Defaults, a=22'b1111111111101000001000 (−1528), b=19 → quotient=22'h3FFFB0 (−80), remainder=22'h3FFFF8 (−8).
- rem_mode=0, a=−1528, b=19 → quotient=−80, remainder=11.
- tc_mode=0, a=22'h3FFFFF, b=0 → divide_by_0=1, quotient=22'h3FFFFF, remainder=22'h3FFFFF.
- tc_mode=1, a=22'h200000, b=−1 → quotient=22'h1FFFFF with SEQ_DIV_OVF_SAT_EN, 22'h200000 without; remainder=0.
- Start a=100, b=7. Deassert rst_n at cycle 10: outputs clear and no done. After release, start a=100, b=7 again → quotient=14, remainder=2. A start pulsed while busy is ignored.
